// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the round-robin memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  localparam int unsigned err_cnt_width_lp = 8;
  localparam logic [err_cnt_width_lp-1:0] err_cnt_max_lp = '1;

  function automatic int unsigned num_data_bytes(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/mem_arbiter_sync_rr_arb_pointer.sv
// Round-robin priority select: first valid requester after last_i, wrapping.
module rr_arb_pointer #(
  parameter int num_req_p   = 2,
  parameter int idx_width_p = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic [num_req_p-1:0]   v_i,
  input  logic [idx_width_p-1:0] last_i,
  output logic [num_req_p-1:0]   grant_o,
  output logic [idx_width_p-1:0] idx_o,
  output logic                   any_o
);

  int                     cand;
  logic [idx_width_p-1:0] cand_idx;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value held and no latch is inferred.
  always_comb begin
    grant_o  = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= num_req_p; k++) begin
      cand = int'(last_i) + k;
      if (cand >= num_req_p) cand = cand - num_req_p;
      cand_idx = idx_width_p'(cand);
      if (!any_o && v_i[cand_idx]) begin
        any_o             = 1'b1;
        idx_o             = cand_idx;
        grant_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_sync.sv
// Round-robin arbiter sharing one single-port synchronous memory among
// num_req_p requesters; reads hold the arbiter until the response is consumed.
module mem_arbiter_sync
  import mem_arb_pkg::*;
#(
  parameter int          num_req_p          = 2,
  parameter int          data_width_p       = 64,
  parameter int          addr_width_p       = 32,
  parameter int unsigned mem_cap_in_bytes_p = 65536
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic [num_req_p-1:0]                 req_v_i,
  output logic [num_req_p-1:0]                 req_ready_o,
  input  logic [num_req_p-1:0]                 req_w_i,
  input  logic [num_req_p*addr_width_p-1:0]    req_addr_i,
  input  logic [num_req_p*data_width_p-1:0]    req_data_i,
  input  logic [num_req_p*(data_width_p/8)-1:0] req_mask_i,
  output logic [num_req_p-1:0]                 resp_v_o,
  output logic [data_width_p-1:0]              resp_data_o,
  output logic                                 resp_err_o,
  input  logic [num_req_p-1:0]                 resp_yumi_i,
  output logic                                 mem_v_o,
  output logic                                 mem_w_o,
  output logic [addr_width_p-1:0]              mem_addr_o,
  output logic [data_width_p-1:0]              mem_data_o,
  output logic [data_width_p/8-1:0]            mem_mask_o,
  input  logic [data_width_p-1:0]              mem_data_i,
  output logic [err_cnt_width_lp-1:0]          err_cnt_o
);

  localparam int unsigned num_bytes_lp = num_data_bytes(data_width_p);
  localparam int idx_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam logic [idx_width_lp-1:0] last_rst_lp  = idx_width_lp'(num_req_p - 1);
  localparam logic [addr_width_p:0]   span_lp      = (addr_width_p + 1)'(num_bytes_lp);
  localparam logic [addr_width_p:0]   cap_lp       = (addr_width_p + 1)'(mem_cap_in_bytes_p);

  state_e                        state_r, state_n;
  logic [idx_width_lp-1:0]       last_r, owner_r, grant_idx;
  logic                          err_r;
  logic [err_cnt_width_lp-1:0]   err_cnt_r;
  logic [num_req_p-1:0]          grant_oh;
  logic                          grant_any, grant_v, in_range, g_w;
  logic [addr_width_p-1:0]       g_addr;
  logic [data_width_p-1:0]       g_data;
  logic [num_bytes_lp-1:0]       g_mask;

  rr_arb_pointer #(
    .num_req_p  (num_req_p),
    .idx_width_p(idx_width_lp)
  ) u_rr_arb_pointer (
    .v_i    (req_v_i),
    .last_i (last_r),
    .grant_o(grant_oh),
    .idx_o  (grant_idx),
    .any_o  (grant_any)
  );

  assign g_addr = req_addr_i[grant_idx*addr_width_p +: addr_width_p];
  assign g_data = req_data_i[grant_idx*data_width_p +: data_width_p];
  assign g_mask = req_mask_i[grant_idx*num_bytes_lp +: num_bytes_lp];
  assign g_w    = req_w_i[grant_idx];

  // One extra bit keeps addr + bytes from wrapping near the top of the space.
  assign in_range = ({1'b0, g_addr} + span_lp) <= cap_lp;
  assign grant_v  = reset_n_i && (state_r == IDLE) && grant_any;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is sampled synchronously on the clock.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_r <= IDLE;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: if (grant_v && !g_w)         state_n = RESP;
      RESP: if (resp_yumi_i[owner_r])    state_n = IDLE;
      default:                           state_n = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = grant_v ? grant_oh : '0;
    mem_v_o     = grant_v && in_range;
    mem_w_o     = grant_v && in_range && g_w;
    mem_addr_o  = g_addr;
    mem_data_o  = g_data;
    mem_mask_o  = g_mask;
    resp_v_o    = '0;
    resp_err_o  = 1'b0;
    resp_data_o = '0;
    if (state_r == RESP) begin
      resp_v_o[owner_r] = 1'b1;
      resp_err_o        = err_r;
      resp_data_o       = err_r ? '0 : mem_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      last_r    <= last_rst_lp;
      owner_r   <= '0;
      err_r     <= 1'b0;
      err_cnt_r <= '0;
    end else if (grant_v) begin
      last_r <= grant_idx;
      if (!g_w) begin
        owner_r <= grant_idx;
        err_r   <= !in_range;
      end
      if (!in_range && (err_cnt_r != err_cnt_max_lp)) err_cnt_r <= err_cnt_r + 1'b1;
    end
  end

  assign err_cnt_o = err_cnt_r;

endmodule
